// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
//   Round-robin arbiter that shares the async FIFO read port among NUM_REQ
//   consumers in the read clock domain. A winner gets the port for a burst of
//   up to MAX_BURST pops. Popped words are forwarded with the owner's index.
//
// Ports
//   r_clk       read-domain clock
//   r_rst       asynchronous active-low reset
//   req         per-consumer level request
//   gnt         one-hot registered grant, zero when idle
//   rempty      FIFO empty flag (r_clk domain)
//   rinc        FIFO pop strobe, combinational
//   rdata       FIFO read data at the current read address
//   out_valid   registered, one pulse per popped word
//   out_data    popped word, registered
//   out_id      index of the consumer owning out_data
//   burst_done  one-cycle pulse when a grant is released
//
// State | meaning
// IDLE  | no grant; pick a winner from req starting at the rr pointer
// BURST | one consumer owns the read port; pop while req held and FIFO not empty
`timescale 1ns/1ps

module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic                  burst_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [7:0]          LAST_CNT = 8'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]   gnt_id_q, gnt_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]            count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
  logic                  burst_done_q, burst_done_d;

  logic                  win_valid;
  logic [ID_WIDTH-1:0]   win_id;
  int                    idx;
  logic                  pop;
  logic                  rel;

  // Search starts at the rr pointer and wraps at NUM_REQ, not 2^ID_WIDTH.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    rr_ptr_d     = rr_ptr_q;
    count_d      = count_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    burst_done_d = 1'b0;
    pop          = 1'b0;
    rel          = 1'b0;

    case (state_q)
      IDLE: begin
        // FIFO level is deliberately ignored here; an empty FIFO just stalls the burst.
        if (win_valid) begin
          state_d        = BURST;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          gnt_id_d       = win_id;
          count_d        = '0;
        end
      end
      BURST: begin
        if (!req[gnt_id_q]) begin
          // Owner walked away: release without popping.
          rel = 1'b1;
        end else if (!rempty) begin
          pop         = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = rdata;
          out_id_d    = gnt_id_q;
          count_d     = count_q + 8'd1;
          if (count_q == LAST_CNT) begin
            rel = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      state_d      = IDLE;
      gnt_d        = '0;
      burst_done_d = 1'b1;
      rr_ptr_d     = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      rr_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign rinc       = pop;
  assign gnt        = gnt_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign burst_done = burst_done_q;

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Round-robin arbiter that shares the async FIFO read port among NUM_REQ consumers in the read clock domain.
- Grants one requester at a time for a burst of up to MAX_BURST pops.
- Drives the FIFO read-increment and forwards popped data tagged with the consumer index.
- Sits between the FIFO read controller/memory read port and the downstream consumers.

Parameters:
- NUM_REQ, 4, number of requesting consumers (2..16).
- DATA_WIDTH, 8, FIFO data width.
- MAX_BURST, 4, maximum pops per grant (1..255).
- ID_WIDTH, 2, width of requester index; must be >= clog2(NUM_REQ).

Ports:
- r_clk  in  1  read-domain clock.
- r_rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-consumer level request; held while the consumer wants data.
- gnt  out  NUM_REQ  one-hot registered grant; all zeros when idle.
- rempty  in  1  FIFO empty flag (registered, r_clk domain).
- rinc  out  1  FIFO pop strobe, combinational.
- rdata  in  DATA_WIDTH  FIFO memory read data at the current read address; valid the same cycle.
- out_valid  out  1  registered; one pulse per popped word.
- out_data  out  DATA_WIDTH  popped word, registered.
- out_id  out  ID_WIDTH  index of the consumer that owns out_data.
- burst_done  out  1  one-cycle registered pulse when a grant is released.

Behaviour:
- Reset (r_rst low, asynchronous) forces the following, regardless of state:
  - state=IDLE; gnt=0; out_valid=0; out_data=0; out_id=0; burst_done=0.
  - burst count=0; rr pointer=0.
  - rinc=0 (combinational from state).
  - Reset mid-burst abandons the burst; no further pops occur.
- FSM states: IDLE, BURST.
- IDLE:
  - gnt=0, rinc=0.
  - If req != 0, pick the winner: the first set bit searching from rr pointer upward, wrapping modulo NUM_REQ.
  - Next edge: gnt=onehot(winner), gnt_id=winner, count=0, state=BURST.
  - rempty is not checked for grant; a requester may be granted while the FIFO is empty.
- BURST:
  - pop = req[gnt_id] & ~rempty; rinc = pop.
  - On a pop edge: out_data<=rdata, out_id<=gnt_id, out_valid<=1, count<=count+1. On any other edge, out_valid<=0.
  - rempty=1: stall in BURST with no pop and count held. No timeout.
- Grant release:
  - Triggers: a pop with count==MAX_BURST-1 (final pop is still performed), or req[gnt_id]==0 (no pop that cycle).
  - On release edge: state=IDLE, gnt=0, burst_done=1 for one cycle, rr pointer=(gnt_id+1) mod NUM_REQ.
- Latency:
  - req to gnt: 1 cycle.
  - gnt to first rinc: same cycle gnt is visible, if req is held and ~rempty.
  - rinc to out_valid: 1 cycle.
  - Back-to-back grants have one IDLE cycle between bursts (minimum re-arbitration gap).
- The block never asserts rinc while rempty=1.
- Throughput: one pop per cycle within a burst.
- Simultaneous events:
  - Requester drops req in the same cycle as the final pop → release with no pop that cycle; burst_done still pulses.
  - Requests arriving while in BURST wait until IDLE.
- Fairness: with all requesters continuously active, grant order is 0,1,2,...,NUM_REQ-1, 0,...
- Width rules:
  - Burst counter is 8 bits, compared to MAX_BURST-1 at full width.
  - rr pointer and gnt_id are ID_WIDTH bits; wrap at NUM_REQ, not 2^ID_WIDTH.

Test Plan:
- Reset check: assert r_rst low mid-burst with FIFO holding 3 words → gnt=0, rinc=0, out_valid=0 immediately; after release, no pops until a new req is seen.
- Single requester, FIFO holding 10 words (0x00..0x09), req=4'b0001 held, MAX_BURST=4:
  - out_data 00,01,02,03 with out_id=0.
  - burst_done pulses, one IDLE cycle, then 04..07, then 08,09.
  - FIFO goes empty: rinc stays 0 and gnt[0] held.
- Round robin: all req=4'b1111, FIFO holding 16 words → grants in order 0,1,2,3, each receiving 4 words with matching out_id; rr pointer ends at 0.
- Empty stall: grant req[2] with FIFO empty → gnt=4'b0100, rinc=0 for 5 cycles. Write one word 0xA5 → after rempty falls, exactly one pop; out_data=0xA5, out_id=2.
- Early drop: req[1] drops after 2 pops → release on that edge with no third pop; burst_done=1; next grant goes to the lowest active index >=2, wrapping.
- Skipping idle requesters: req=4'b1001 with rr pointer=1 → grant goes to 3, then to 0.
